// File: rtl/band_power_acc.sv
// band_power_acc: windowed mean-square power of a band-filtered sample stream.
// Pipeline: shift+saturate -> square -> window accumulate, result held
// behind a valid/ready handshake with a sticky overrun flag.
module band_power_acc #(
  parameter int WIN_LOG2 = 8,
  parameter int SHIFT    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] x,
  input  logic        clear,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] power,
  output logic        overrun
);

  localparam int ACCW = 32 + WIN_LOG2;
  // Counter value on which the window switches to its last sample.
  localparam logic [WIN_LOG2-1:0] CNT_PRE = WIN_LOG2'((1 << WIN_LOG2) - 2);

  typedef enum logic {ACC, LAST} state_t;

  state_t              state;
  logic [1:0]          vld_pipe;   // [0] stage 1, [1] stage 2
  logic signed [15:0]  xs_q;
  logic [31:0]         sq_q;
  logic [ACCW-1:0]     acc;
  logic [WIN_LOG2-1:0] cnt;

  logic signed [31:0]  xsh;
  logic signed [15:0]  xs_sat;
  logic signed [31:0]  xs_ext;
  logic signed [31:0]  prod;
  logic [ACCW-1:0]     total;
  logic                close;

  assign xsh = $signed(x) >>> SHIFT;

  // Clamp the shifted sample into signed 16 bits so the square fits 32 bits.
  always_comb begin
    xs_sat = xsh[15:0];
    if (xsh > 32'sd32767)       xs_sat = 16'sh7fff;
    else if (xsh < -32'sd32768) xs_sat = 16'sh8000;
  end

  assign xs_ext = 32'(xs_q);
  assign prod   = xs_ext * xs_ext;
  assign total  = acc + ACCW'(sq_q);
  assign close  = vld_pipe[1] & ~clear & (state == LAST);

  // Two-stage datapath; clear kills everything in flight plus the incoming sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      xs_q     <= '0;
      sq_q     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0] & ~clear, in_valid & ~clear};
      xs_q     <= xs_sat;
      sq_q     <= unsigned'(prod);
    end
  end

  // Window FSM, accumulator and handshaked result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      power     <= '0;
      overrun   <= 1'b0;
    end else begin
      if (clear) begin
        state <= ACC;
        acc   <= '0;
        cnt   <= '0;
      end else if (vld_pipe[1]) begin
        case (state)
          ACC: begin
            acc <= total;
            cnt <= cnt + WIN_LOG2'(1);
            if (cnt == CNT_PRE) state <= LAST;
          end
          LAST: begin
            // Closing square goes straight into power; next window starts empty.
            acc   <= '0;
            cnt   <= '0;
            state <= ACC;
          end
          default: state <= ACC;
        endcase
      end

      if (close) begin
        power     <= total[WIN_LOG2 +: 32];
        out_valid <= 1'b1;
        if (out_valid && !out_ready) overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_band_power_acc.sv
// Scoreboard bench for band_power_acc (WIN_LOG2=2, SHIFT=4): the driver feeds a
// window-level reference model, a negedge monitor pops results on each handshake.
module tb_band_power_acc;

  localparam int WIN_LOG2 = 2;
  localparam int SHIFT    = 4;
  localparam int N        = 1 << WIN_LOG2;

  logic        clk = 1'b0;
  logic        reset, in_valid, clear, out_ready;
  logic [31:0] x;
  logic        out_valid, overrun;
  logic [31:0] power;

  band_power_acc #(.WIN_LOG2(WIN_LOG2), .SHIFT(SHIFT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .clear(clear),
    .out_ready(out_ready), .out_valid(out_valid), .power(power), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int      vectors = 0;
  int      miscompares = 0;
  longint  expq[$];
  longint  msum = 0;
  int      mcnt = 0;
  logic    exp_ovr = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: floor-divide by 2^SHIFT, clamp to int16, square.
  function automatic longint sq_of(input logic [31:0] xv);
    longint v;
    v = longint'($signed(xv));
    v = v >>> SHIFT;
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v * v;
  endfunction

  function automatic void model_reset();
    msum = 0;
    mcnt = 0;
  endfunction

  function automatic void model_step(input logic iv, input logic [31:0] xv, input logic clr);
    if (clr) begin
      model_reset();
    end else if (iv) begin
      msum += sq_of(xv);
      mcnt++;
      if (mcnt == N) begin
        expq.push_back(msum / N);
        model_reset();
      end
    end
  endfunction

  // One clock of stimulus; inputs change 1 time unit after the edge.
  task automatic cyc(input logic iv, input logic [31:0] xv, input logic clr, input logic rdy);
    @(posedge clk); #1;
    in_valid  = iv;
    x         = xv;
    clear     = clr;
    out_ready = rdy;
    model_step(iv, xv, clr);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 1'b0, rdy);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b1; clear = 1'b1; x = 32'd160; out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; clear = 1'b0; x = 32'd0;
    model_reset();
    expq.delete();
    exp_ovr = 1'b0;
  endtask

  // Scoreboard monitor: a result is consumed at the next edge when valid && ready.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        chk("unexpected_result", longint'(power), -1);
      end else begin
        chk("power", longint'(power), expq.pop_front());
      end
      chk("overrun_at_pop", longint'(overrun), longint'(exp_ovr));
    end
  end

  initial begin
    logic [31:0] xv;
    int wd;
    reset = 1'b1; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0; x = '0;
    repeat (3) @(posedge clk);
    do_reset();
    #1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_power", longint'(power), 0);
    chk("rst_overrun", longint'(overrun), 0);

    // Basic mean plus latency: result appears on the third edge after the last sample is presented.
    cyc(1, 32'd160, 0, 1);
    cyc(1, -32'sd160, 0, 1);
    cyc(1, 32'd160, 0, 1);
    cyc(1, -32'sd160, 0, 1);
    cyc(0, 0, 0, 1);                 // edge 1 captures the sample
    @(posedge clk); #1;
    chk("lat_edge2_valid", longint'(out_valid), 0);
    @(posedge clk); #1;
    chk("lat_edge3_valid", longint'(out_valid), 1);
    chk("basic_power", longint'(power), 100);
    @(posedge clk); #1;
    chk("pulse_drop", longint'(out_valid), 0);

    // Saturation at both rails.
    for (int i = 0; i < N; i++) cyc(1, 32'h7fffffff, 0, 1);
    idle(4, 1);
    for (int i = 0; i < N; i++) cyc(1, 32'h80000000, 0, 1);
    idle(4, 1);

    // Overrun: two windows with no consumer.
    for (int i = 0; i < N; i++) cyc(1, 32'd160, 0, 0);
    idle(3, 0);
    chk("ovr_first_valid", longint'(out_valid), 1);
    chk("ovr_first_flag", longint'(overrun), 0);
    for (int i = 0; i < N; i++) cyc(1, 32'd160, 0, 0);
    idle(3, 0);
    chk("ovr_valid", longint'(out_valid), 1);
    chk("ovr_power", longint'(power), 100);
    chk("ovr_flag", longint'(overrun), 1);
    void'(expq.pop_front());          // overwritten result is never seen
    exp_ovr = 1'b1;
    idle(3, 1);
    chk("ovr_after_pop_valid", longint'(out_valid), 0);
    cyc(0, 0, 1, 1);                  // clear must not touch overrun
    idle(2, 1);
    chk("ovr_sticky", longint'(overrun), 1);
    do_reset();
    #1;
    chk("ovr_reset", longint'(overrun), 0);

    // Clear mid-window, then clear coinciding with a sample.
    cyc(1, 32'd320, 0, 1);
    cyc(1, 32'd320, 0, 1);
    cyc(0, 0, 1, 1);
    for (int i = 0; i < N; i++) cyc(1, 32'd160, 0, 1);
    idle(4, 1);
    cyc(1, 32'd320, 1, 1);
    for (int i = 0; i < N; i++) cyc(1, 32'd160, 0, 1);
    idle(4, 1);

    // Back-to-back windows: x = 16*k.
    for (int k = 1; k <= 12; k++) cyc(1, 32'(16 * k), 0, 1);
    idle(4, 1);
    chk("b2b_drained", longint'(expq.size()), 0);

    // Reset mid-window discards the partial window.
    for (int i = 0; i < 3; i++) cyc(1, 32'd160, 0, 1);
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) cyc(1, 32'd80, 0, 1);
    idle(4, 1);
    chk("rstmid_overrun", longint'(overrun), 0);

    // Randomized traffic: gaps, isolated ready stalls, occasional clear after idle.
    begin
      logic last_rdy = 1'b1;
      logic rdy;
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(0, 49) == 0) begin
          idle(3, 1);
          cyc(0, 0, 1, 1);
          last_rdy = 1'b1;
        end else begin
          rdy = (last_rdy && $urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
          last_rdy = rdy;
          xv = $urandom;
          xv = 32'($signed(xv) >>> $urandom_range(0, 31));
          cyc(($urandom_range(0, 9) < 7), xv, 0, rdy);
        end
      end
    end
    idle(6, 1);

    wd = 0;
    while (expq.size() != 0 && wd < 50) begin
      idle(1, 1);
      wd++;
    end
    chk("final_drained", longint'(expq.size()), 0);
    chk("final_overrun", longint'(overrun), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
